load_store_unit: RTL and testbench

- Sits between the multi-cycle CPU control/datapath and the data memory; sequences every LW/LH/LHU/LB/LBU/SW/SH/SB access.
- Registers the request and checks alignment and address range; an invalid request raises addr_err and never touches memory.
- Drives the data memory enable, write-enable, size selects and address for exactly one cycle per valid access.
- For loads, captures the memory read data and sign- or zero-extends it into rdata.

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus between the CPU/data memory and the load/store unit.
// slave: the LSU side; master: CPU request side plus data memory.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        addr_err;
    logic        busy;
    logic        dm_ena;
    logic        dm_wena;
    logic [1:0]  dm_w_cs;
    logic [1:0]  dm_r_cs;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, dm_rdata,
        output rdata, done, addr_err, busy,
        output dm_ena, dm_wena, dm_w_cs, dm_r_cs, dm_addr, dm_wdata
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, dm_rdata,
        input  rdata, done, addr_err, busy,
        input  dm_ena, dm_wena, dm_w_cs, dm_r_cs, dm_addr, dm_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: validates a request, drives one memory cycle,
// extends load data. Ports: clk, rst_n, bus (load_store_unit_if.slave).
module load_store_unit #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    // 33 bits so the top of a range ending at 4 GiB cannot wrap
    localparam logic [32:0] LAST_ADDR =
        {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS) - 33'd1;

    logic [1:0]  state;
    logic [31:0] a_addr;
    logic        a_we;
    logic [1:0]  a_size;
    logic        a_sign;
    logic [31:0] a_wdata;
    logic [31:0] rdata_q;

    logic        bad_req;
    logic [31:0] ld_ext;
    logic        in_access;

    always_comb begin
        bad_req = 1'b0;
        if (bus.size == 2'b00)
            bad_req = 1'b1;
        if (bus.size == SZ_HALF && bus.addr[0])
            bad_req = 1'b1;
        if (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00)
            bad_req = 1'b1;
        if ({1'b0, bus.addr} < {1'b0, BASE_ADDR})
            bad_req = 1'b1;
        if ({1'b0, bus.addr} > LAST_ADDR)
            bad_req = 1'b1;
    end

    // memory returns half/byte data zero-padded in the low bits
    always_comb begin
        ld_ext = bus.dm_rdata;
        unique case (1'b1)
            (a_size == SZ_BYTE):
                ld_ext = {{24{a_sign & bus.dm_rdata[7]}},
                          bus.dm_rdata[7:0]};
            (a_size == SZ_HALF):
                ld_ext = {{16{a_sign & bus.dm_rdata[15]}},
                          bus.dm_rdata[15:0]};
            default:
                ld_ext = bus.dm_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_addr  <= '0;
            a_we    <= 1'b0;
            a_size  <= 2'b00;
            a_sign  <= 1'b0;
            a_wdata <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req) begin
                        a_addr  <= bus.addr;
                        a_we    <= bus.we;
                        a_size  <= bus.size;
                        a_sign  <= bus.sign_ext;
                        a_wdata <= bus.wdata;
                        state   <= bad_req ? ERROR : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!a_we)
                        rdata_q <= ld_ext;
                    state <= FINISH;
                end
                FINISH:  state <= IDLE;
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // memory strobes decode straight from state so reset kills them
    assign in_access = (state == ACCESS);

    assign bus.dm_ena   = in_access;
    assign bus.dm_wena  = in_access & a_we;
    assign bus.dm_w_cs  = (in_access &  a_we) ? a_size : 2'b00;
    assign bus.dm_r_cs  = (in_access & ~a_we) ? a_size : 2'b00;
    assign bus.dm_addr  = a_addr;
    assign bus.dm_wdata = a_wdata;

    assign bus.rdata    = rdata_q;
    assign bus.done     = (state == FINISH) | (state == ERROR);
    assign bus.addr_err = (state == ERROR);
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: data memory, byte-level reference
// model, directed cases and random accesses.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h10010000;
    localparam int          DEPTH = 1024;

    logic clk;
    logic rst_n;

    load_store_unit_if bus ();

    load_store_unit #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] dm    [DEPTH];
    logic [7:0]  ref_b [4*DEPTH];
    logic [31:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // data memory: word array, byte/half lanes picked by address
    function automatic logic [9:0] widx(input logic [31:0] a);
        logic [31:0] d;
        d = (a - BASE) >> 2;
        return d[9:0];
    endfunction

    always @(posedge clk) begin
        if (bus.dm_ena && bus.dm_wena) begin
            case (bus.dm_w_cs)
                2'b01: dm[widx(bus.dm_addr)] <= bus.dm_wdata;
                2'b10: dm[widx(bus.dm_addr)][16*bus.dm_addr[1] +: 16]
                           <= bus.dm_wdata[15:0];
                2'b11: dm[widx(bus.dm_addr)][8*bus.dm_addr[1:0] +: 8]
                           <= bus.dm_wdata[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        logic [31:0] w;
        w = dm[widx(bus.dm_addr)];
        bus.dm_rdata = w;
        case (bus.dm_r_cs)
            2'b10: bus.dm_rdata = {16'h0, w[16*bus.dm_addr[1] +: 16]};
            2'b11: bus.dm_rdata = {24'h0, w[8*bus.dm_addr[1:0] +: 8]};
            default: bus.dm_rdata = w;
        endcase
    end

    // reference model: flat byte array, little-endian
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 4 : (sz == 2'b10) ? 2 : 1;
    endfunction

    function automatic bit model_err(input logic [1:0] sz,
                                     input logic [31:0] a);
        longint la;
        la = longint'(a);
        if (sz == 2'b00) return 1'b1;
        if (sz == 2'b10 && (a % 2) != 0) return 1'b1;
        if (sz == 2'b01 && (a % 4) != 0) return 1'b1;
        if (la < longint'(BASE)) return 1'b1;
        if (la >= longint'(BASE) + 4 * DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_store(input logic [1:0] sz,
                               input logic [31:0] a,
                               input logic [31:0] wd);
        int off;
        off = int'(a - BASE);
        for (int i = 0; i < nbytes(sz); i++)
            ref_b[off + i] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] sz,
                                               input logic sx,
                                               input logic [31:0] a);
        int     off;
        int     n;
        longint v;
        off = int'(a - BASE);
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++)
            v = v + (longint'(ref_b[off + i]) << (8 * i));
        if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic all_outs_or(input int dummy);
        return (|bus.rdata) | bus.done | bus.addr_err | bus.busy |
               bus.dm_ena | bus.dm_wena | (|bus.dm_w_cs) |
               (|bus.dm_r_cs) | (|bus.dm_addr) | (|bus.dm_wdata) |
               logic'(dummy != 0);
    endfunction

    task automatic do_access(input logic w, input logic [1:0] sz,
                             input logic sx, input logic [31:0] a,
                             input logic [31:0] wd);
        bit err;
        int lat;
        int nacc;
        err = model_err(sz, a);
        @(negedge clk);
        bus.req = 1'b1;
        bus.we = w;
        bus.size = sz;
        bus.sign_ext = sx;
        bus.addr = a;
        bus.wdata = wd;
        @(posedge clk);
        lat = 0;
        nacc = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req = 1'b0;
                check("busy_after_req", bus.busy, 1);
            end
            if (bus.dm_ena) begin
                nacc++;
                check("dm_addr", bus.dm_addr, a);
                check("dm_wena", bus.dm_wena, w);
                check("dm_w_cs", bus.dm_w_cs, w ? sz : 2'b00);
                check("dm_r_cs", bus.dm_r_cs, w ? 2'b00 : sz);
                if (w) check("dm_wdata", bus.dm_wdata, wd);
            end
            if (bus.done) begin
                lat = k;
                check("addr_err", bus.addr_err, err);
            end
        end
        if (lat == 0)
            check("done_timeout", 0, 1);
        else
            check("latency", lat + 1, err ? 2 : 3);
        check("accesses", nacc, err ? 0 : 1);
        if (!err && w) model_store(sz, a, wd);
        if (!err && !w) exp_rdata = model_load(sz, sx, a);
        check("rdata", bus.rdata, exp_rdata);
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
    endtask

    initial begin
        int          nacc;
        logic [1:0]  sz;
        logic [31:0] a;
        int          off;

        for (int i = 0; i < DEPTH; i++) dm[i] = '0;
        for (int i = 0; i < 4 * DEPTH; i++) ref_b[i] = '0;
        exp_rdata = '0;
        rst_n = 1'b0;
        bus.req = 1'b0;
        bus.we = 1'b0;
        bus.size = 2'b00;
        bus.sign_ext = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs_or(0), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", bus.busy, 0);

        // word round trip
        do_access(1, 2'b01, 0, 32'h10010010, 32'hDEADBEEF);
        do_access(0, 2'b01, 0, 32'h10010010, 32'h0);
        check("lw_const", bus.rdata, 32'hDEADBEEF);

        // byte extension
        do_access(1, 2'b11, 0, 32'h10010003, 32'h00000080);
        do_access(0, 2'b11, 1, 32'h10010003, 32'h0);
        check("lb_const", bus.rdata, 32'hFFFFFF80);
        do_access(0, 2'b11, 0, 32'h10010003, 32'h0);
        check("lbu_const", bus.rdata, 32'h00000080);
        do_access(0, 2'b01, 0, 32'h10010000, 32'h0);
        check("lw_byte_const", bus.rdata, 32'h80000000);

        // half extension
        do_access(1, 2'b10, 0, 32'h10010002, 32'h00008001);
        do_access(0, 2'b10, 1, 32'h10010002, 32'h0);
        check("lh_const", bus.rdata, 32'hFFFF8001);
        do_access(0, 2'b10, 0, 32'h10010002, 32'h0);
        check("lhu_const", bus.rdata, 32'h00008001);

        // errors
        do_access(0, 2'b10, 1, 32'h10010001, 32'h0);
        check("err_rdata_kept", bus.rdata, 32'h00008001);
        do_access(1, 2'b01, 0, 32'h10010FFC, 32'hCAFEF00D);
        do_access(1, 2'b01, 0, 32'h10011000, 32'h55555555);
        do_access(0, 2'b01, 0, 32'h10010FFC, 32'h0);
        check("word1023_kept", bus.rdata, 32'hCAFEF00D);
        do_access(0, 2'b00, 0, 32'h10010010, 32'h0);
        do_access(0, 2'b01, 0, 32'h1000FFFC, 32'h0);

        // req held high: accepted only in IDLE, once every 3 cycles
        @(negedge clk);
        bus.req = 1'b1;
        bus.we = 1'b0;
        bus.size = 2'b01;
        bus.sign_ext = 1'b0;
        bus.addr = 32'h10010010;
        nacc = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (bus.dm_ena) nacc++;
            check("b2b_busy", bus.busy, (k % 3) != 0);
        end
        bus.req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.dm_ena) nacc++;
        end
        check("b2b_accesses", nacc, 3);
        exp_rdata = model_load(2'b01, 0, 32'h10010010);
        check("b2b_rdata", bus.rdata, exp_rdata);

        // reset during the ACCESS cycle of a store
        do_access(1, 2'b01, 0, 32'h10010020, 32'h11112222);
        @(negedge clk);
        bus.req = 1'b1;
        bus.we = 1'b1;
        bus.size = 2'b01;
        bus.addr = 32'h10010020;
        bus.wdata = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        check("ena_before_rst", bus.dm_ena, 1);
        rst_n = 1'b0;
        #1;
        check("ena_async_drop", bus.dm_ena, 0);
        check("outs_in_reset", all_outs_or(0), 0);
        @(posedge clk);
        @(negedge clk);
        check("outs_in_reset2", all_outs_or(0), 0);
        rst_n = 1'b1;
        exp_rdata = '0;
        do_access(0, 2'b01, 0, 32'h10010020, 32'h0);
        check("rst_no_write", bus.rdata, 32'h11112222);

        // random accesses
        for (int n = 0; n < 300; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'b00
                 : 2'($urandom_range(1, 3));
            off = int'($urandom_range(0, 4 * DEPTH - 1));
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'b01) off = off & ~3;
                if (sz == 2'b10) off = off & ~1;
            end
            a = BASE + 32'(off);
            if ($urandom_range(0, 9) == 0)
                a = BASE - 32'($urandom_range(1, 8));
            else if ($urandom_range(0, 9) == 0)
                a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 8));
            do_access(1'($urandom_range(0, 1)), sz,
                      1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
